// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one async SRAM between IF reads and MEM read/write with alternating priority.
// Define MEM_ARB_STATS_EN to add a saturating stall_cnt output.
module mem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 1
) (
  input  logic              clk_50MHz,
  input  logic              rst,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);
  typedef enum logic [2:0] {IDLE, RD_MEM, WR_SETUP, WR_PULSE, RD_IF} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic last_mem_q, last_mem_d;
  logic if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic if_pend, mem_pend, grant_mem;
  // a request still high during its own ready cycle is the one just served
  assign if_pend   = if_req & ~if_ready_q;
  assign mem_pend  = mem_req & ~mem_ready_q;
  assign grant_mem = mem_pend & (~if_pend | ~last_mem_q);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_mem) begin
          state_d     = mem_wr ? WR_SETUP : RD_MEM;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wr ? mem_wdata : ram_wdata_q;
        end else if (if_pend) begin
          state_d    = RD_IF;
          ram_addr_d = if_addr;
        end
      end
      RD_MEM, RD_IF: begin
        if (cnt_q == 2'(RD_WAIT)) begin
          state_d     = IDLE;
          last_mem_d  = state_q == RD_MEM;
          mem_ready_d = state_q == RD_MEM;
          if_ready_d  = state_q == RD_IF;
          mem_rdata_d = state_q == RD_MEM ? ram_rdata : mem_rdata_q;
          if_rdata_d  = state_q == RD_IF ? ram_rdata : if_rdata_q;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        state_d     = IDLE;
        mem_ready_d = 1'b1;
        last_mem_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ce_n_d = state_d == IDLE;
    oe_n_d = !(state_d == RD_MEM || state_d == RD_IF);
    we_n_d = state_d != WR_PULSE;
  end
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_mem_q  <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_stall = mem_req & ~mem_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = ((if_stall | mem_stall) && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  always_ff @(posedge clk_50MHz) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit external SRAM between two requesters: instruction fetch (IF, read-only) and the EXE/MEM stage data access (MEM, read/write, driven from em_RAM_en/em_RAM_op/em_ALU_data/em_RAM_WB_data).
- Sequences SRAM control strobes with a small FSM.
- Returns read data and one-cycle ready pulses.
- Raises per-requester stall signals that the hazard logic uses to freeze IF_ID/ID_EXE/EXE_MEM.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, data width.
- RD_WAIT, 1, extra wait cycles in read states (0..3); read occupancy is RD_WAIT+1 cycles.

Ports:
- clk_50MHz  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held until if_ready.
- if_addr  in  ADDR_W  IF read address.
- if_rdata  out  DATA_W  IF read data; registered, valid when if_ready=1.
- if_ready  out  1  one-cycle pulse: IF access complete.
- if_stall  out  1  if_req & ~if_ready (combinational).
- mem_req  in  1  MEM access request (em_RAM_en); held until mem_ready.
- mem_wr  in  1  1=write, 0=read (em_RAM_op).
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_rdata  out  DATA_W  MEM read data; registered.
- mem_ready  out  1  one-cycle pulse: MEM access complete.
- mem_stall  out  1  mem_req & ~mem_ready (combinational).
- ram_addr  out  ADDR_W  SRAM address (registered).
- ram_wdata  out  DATA_W  SRAM write data (registered).
- ram_rdata  in  DATA_W  SRAM read data.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low (registered).

Behaviour:
- Reset (rst=1 at an edge):
  - State IDLE; ram_ce_n/oe_n/we_n=1; ram_addr=0; ram_wdata=0.
  - if_rdata=0; mem_rdata=0; both ready=0; wait counter=0; last_grant=IF.
  - Reset mid-operation aborts it: strobes go inactive on that same edge and no ready pulse is issued.
- States: IDLE, RD_MEM, WR_SETUP, WR_PULSE, RD_IF.
- Arbitration (IDLE only, requests sampled at the edge):
  - Only mem_req: grant MEM.
  - Only if_req: grant IF.
  - Both pending: grant MEM unless last_grant=MEM, in which case grant IF. No requester waits more than one other access.
  - Neither: stay IDLE, all strobes inactive.
- Grant latches address (and wdata for writes) into ram_addr/ram_wdata. Request inputs are not resampled until the next IDLE.
- Grant MEM read → RD_MEM: ce_n=0, oe_n=0. Counter counts RD_WAIT cycles. On the final cycle, ram_rdata is captured into mem_rdata, mem_ready=1 for one cycle, state goes to IDLE, last_grant=MEM.
- Grant IF → RD_IF: identical timing. Result goes to if_rdata/if_ready; last_grant=IF.
- Grant MEM write:
  - WR_SETUP, 1 cycle: ce_n=0, oe_n=1, we_n=1, addr and data stable.
  - WR_PULSE, 1 cycle: we_n=0.
  - On leaving WR_PULSE: we_n=1, mem_ready=1, state to IDLE, last_grant=MEM.
  - ram_addr/ram_wdata hold through the we_n rising edge.
- Latency from grant edge to ready pulse: reads RD_WAIT+1 cycles, writes 2 cycles. A new access can be granted in the cycle after ready; IDLE is occupied for one cycle minimum.
- ready pulses are asserted only in the completion cycle and are never set in IDLE.
- rdata registers hold their value until the next completion for that requester.
- Request dropped mid-access: the access still completes and the ready pulse still fires; the requester ignores it.
- ram_we_n and ram_oe_n are never both 0.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined, adds output stall_cnt [15:0], which counts clock cycles with (if_stall | mem_stall)=1. It saturates at 16'hFFFF and is cleared by rst.
- When undefined, the port and counter are absent and there is no behavioural change otherwise.

Test Plan:
- Reset: assert rst 2 cycles mid-write (in WR_PULSE) → next edge ram_we_n=1, ram_ce_n=1, mem_ready never pulses, state IDLE.
- IF read, RD_WAIT=1: if_req=1, if_addr=18'h00010, ram_rdata=16'h1234 → ram_oe_n low 2 cycles, if_ready pulses on 3rd edge after request, if_rdata=16'h1234, if_stall low same cycle.
- MEM write: mem_req=1, mem_wr=1, addr=18'h0BF00, wdata=16'hA5A5 → 1 cycle we_n=1 setup, 1 cycle we_n=0 with addr/data stable, mem_ready pulse, SRAM model holds 16'hA5A5.
- Contention: if_req and mem_req held continuously (MEM reads) → grants alternate MEM, IF, MEM, IF…; each ready pulse exactly once per grant.
- Dropped request: mem_req deasserted during RD_MEM → access completes, mem_ready pulses once, next IDLE grants IF if pending.
- MEM_ARB_STATS_EN defined: 5 stall cycles → stall_cnt=5; force 70000 stall cycles → stall_cnt=16'hFFFF.
